// File: rtl/crc_fcs_ctrl.sv
// crc_fcs_ctrl: frames a payload byte stream with optional zero pad and
// a 4-byte Ethernet-style FCS computed by an attached CRC-32 engine.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_data/s_valid/     payload input stream, s_last on the final byte
//   s_last/s_ready
//   m_data/m_valid/     framed output (payload, pad, FCS), m_last on
//   m_last/m_ready      FCS byte 3
//   crc_en/crc_byte/    byte feed and reload strobe to the crc_engine,
//   crc_clr/crc_in      current engine register back
//   busy, frame_cnt     frame in progress; completed frame count
module crc_fcs_ctrl #(
    parameter int PAD_EN  = 1,
    parameter int MIN_LEN = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        crc_en,
    output logic [7:0]  crc_byte,
    output logic        crc_clr,
    input  logic [31:0] crc_in,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        FCS  = 2'd3
    } state_t;

    localparam logic [16:0] MIN_L  = 17'(MIN_LEN);
    localparam bit          PAD_ON = (PAD_EN != 0);

    state_t      state;
    state_t      state_nx;
    logic        ready_en;
    logic [15:0] byte_cnt;
    logic [31:0] fcs_reg;
    logic [1:0]  fcs_idx;
    logic        fcs_first;

    logic        free;
    logic        accept;
    logic [16:0] cnt_plus;
    logic [31:0] fcs_word;
    logic [7:0]  fcs_byte;

    logic        load;
    logic [7:0]  load_data;
    logic        load_last;
    logic        cnt_inc;
    logic        cnt_clr;
    logic        fcs_step;

    assign free     = !m_valid || m_ready;
    // ready_en keeps s_ready low until the first edge after reset release
    assign s_ready  = ready_en && (state == IDLE || state == DATA) && free;
    assign accept   = s_valid && s_ready;
    assign busy     = (state != IDLE);
    assign cnt_plus = {1'b0, byte_cnt} + 17'd1;

    // On the first FCS cycle the engine output is used directly so that
    // byte 0 can leave in the same cycle the FCS word is captured.
    always_comb begin
        fcs_word = fcs_first ? ~crc_in : fcs_reg;
        unique case (fcs_idx)
            2'd0:    fcs_byte = fcs_word[7:0];
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            default: fcs_byte = fcs_word[31:24];
        endcase
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        load_data = 8'h00;
        load_last = 1'b0;
        crc_en    = 1'b0;
        crc_byte  = 8'h00;
        crc_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        fcs_step  = 1'b0;
        unique case (state)
            IDLE, DATA: begin
                if (accept) begin
                    load      = 1'b1;
                    load_data = s_data;
                    crc_en    = 1'b1;
                    crc_byte  = s_data;
                    cnt_inc   = 1'b1;
                    state_nx  = DATA;
                    if (s_last) begin
                        if (PAD_ON && (cnt_plus < MIN_L))
                            state_nx = PAD;
                        else
                            state_nx = FCS;
                    end
                end
            end
            PAD: begin
                if (free) begin
                    load     = 1'b1;
                    crc_en   = 1'b1;
                    cnt_inc  = 1'b1;
                    if (cnt_plus >= MIN_L)
                        state_nx = FCS;
                end
            end
            FCS: begin
                if (free) begin
                    load      = 1'b1;
                    load_data = fcs_byte;
                    fcs_step  = 1'b1;
                    if (fcs_idx == 2'd3) begin
                        load_last = 1'b1;
                        crc_clr   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nx  = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_en  <= 1'b0;
            m_data    <= 8'h00;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            byte_cnt  <= 16'h0000;
            frame_cnt <= 16'h0000;
            fcs_reg   <= 32'h0000_0000;
            fcs_idx   <= 2'd0;
            fcs_first <= 1'b0;
        end else begin
            state    <= state_nx;
            ready_en <= 1'b1;

            if (load) begin
                m_data  <= load_data;
                m_valid <= 1'b1;
                m_last  <= load_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            if (cnt_clr)
                byte_cnt <= 16'h0000;
            else if (cnt_inc && byte_cnt != 16'hFFFF)
                byte_cnt <= byte_cnt + 16'd1;

            if (cnt_clr)
                frame_cnt <= frame_cnt + 16'd1;

            if (fcs_first)
                fcs_reg <= ~crc_in;
            fcs_first <= (state_nx == FCS) && (state != FCS);

            // two-bit index wraps back to 0 after byte 3
            if (fcs_step)
                fcs_idx <= fcs_idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_crc_fcs_ctrl.sv
// tb_crc_fcs_ctrl: randomized self-checking bench for crc_fcs_ctrl with
// a behavioural CRC-32 engine and frame model.
module tb_crc_fcs_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sel;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        m_ready;
    bit          rnd;

    logic        sv        [2];
    logic        s_ready   [2];
    logic [7:0]  m_data    [2];
    logic        m_valid   [2];
    logic        m_last    [2];
    logic        crc_en    [2];
    logic [7:0]  crc_byte  [2];
    logic        crc_clr   [2];
    logic [31:0] eng       [2];
    logic        busy      [2];
    logic [15:0] frame_cnt [2];

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] oq [2][$];
    int         nen     [2];
    int         nclr    [2];
    int         nlast   [2];
    int         lastpos [2];
    bit         stalled [2];
    logic [7:0] hd      [2];
    logic       hl      [2];

    always #5 clk = ~clk;

    assign sv[0] = s_valid && !sel;
    assign sv[1] = s_valid && sel;

    crc_fcs_ctrl #(.PAD_EN(0), .MIN_LEN(60)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(sv[0]), .s_last(s_last),
        .s_ready(s_ready[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_last(m_last[0]),
        .m_ready(m_ready),
        .crc_en(crc_en[0]), .crc_byte(crc_byte[0]),
        .crc_clr(crc_clr[0]), .crc_in(eng[0]),
        .busy(busy[0]), .frame_cnt(frame_cnt[0])
    );

    crc_fcs_ctrl #(.PAD_EN(1), .MIN_LEN(60)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(sv[1]), .s_last(s_last),
        .s_ready(s_ready[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_last(m_last[1]),
        .m_ready(m_ready),
        .crc_en(crc_en[1]), .crc_byte(crc_byte[1]),
        .crc_clr(crc_clr[1]), .crc_in(eng[1]),
        .busy(busy[1]), .frame_cnt(frame_cnt[1])
    );

    function automatic logic [31:0] crc8(input logic [31:0] c,
                                         input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n)          eng[k] <= 32'hFFFF_FFFF;
            else if (crc_clr[k]) eng[k] <= 32'hFFFF_FFFF;
            else if (crc_en[k])  eng[k] <= crc8(eng[k], crc_byte[k]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                stalled[k] = 1'b0;
            end else begin
                if (stalled[k]) begin
                    chk("hold_valid", 32'(m_valid[k]), 32'd1);
                    chk("hold_data", 32'(m_data[k]), 32'(hd[k]));
                    chk("hold_last", 32'(m_last[k]), 32'(hl[k]));
                end
                stalled[k] = m_valid[k] && !m_ready;
                hd[k] = m_data[k];
                hl[k] = m_last[k];
                if (m_valid[k] && m_ready) begin
                    oq[k].push_back(m_data[k]);
                    if (m_last[k]) begin
                        nlast[k]++;
                        lastpos[k] = oq[k].size();
                    end
                end
                if (crc_en[k])  nen[k]++;
                if (crc_clr[k]) nclr[k]++;
                chk("en_clr_excl", 32'(crc_en[k] & crc_clr[k]), 32'd0);
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    function automatic void build(input bit k, input logic [7:0] p[$],
                                  output logic [7:0] e[$]);
        logic [31:0] c;
        e = p;
        if (k)
            while (e.size() < 60) e.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (e[i]) c = crc8(c, e[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) e.push_back(c[8*i +: 8]);
    endfunction

    task automatic clear_mon(input bit k);
        oq[k].delete();
        nen[k] = 0;
        nclr[k] = 0;
        nlast[k] = 0;
        lastpos[k] = 0;
    endtask

    task automatic send(input bit k, input logic [7:0] p[$],
                        input bit fin);
        bit ok;
        sel = k;
        foreach (p[i]) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_last = 1'($urandom);
                s_data = 8'($urandom);
                @(posedge clk);
                #1;
            end
            s_data = p[i];
            s_last = fin && (i == p.size() - 1);
            s_valid = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 2000 && !ok; c++) begin
                @(negedge clk);
                ok = s_ready[k];
                @(posedge clk);
                #1;
            end
            if (!ok) chk("send_timeout", 32'd0, 32'd1);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_out(input bit k, input int n);
        for (int c = 0; c < 5000 && oq[k].size() < n; c++)
            @(posedge clk);
        chk("out_timeout", 32'(oq[k].size() >= n), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_bytes(input bit k, input logic [7:0] e[$]);
        chk("out_len", 32'(oq[k].size()), 32'(e.size()));
        foreach (e[i])
            if (i < oq[k].size())
                chk($sformatf("byte%0d", i), 32'(oq[k][i]), 32'(e[i]));
    endtask

    task automatic check_residue(input bit k);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        foreach (oq[k][i]) r = crc8(r, oq[k][i]);
        chk("residue", r, 32'hDEBB20E3);
    endtask

    task automatic run_frame(input bit k, input logic [7:0] p[$]);
        logic [7:0] e[$];
        build(k, p, e);
        clear_mon(k);
        send(k, p, 1'b1);
        wait_out(k, e.size());
        check_bytes(k, e);
        check_residue(k);
        chk("crc_en_cnt", 32'(nen[k]), 32'(e.size() - 4));
        chk("crc_clr_cnt", 32'(nclr[k]), 32'd1);
        chk("last_cnt", 32'(nlast[k]), 32'd1);
        chk("last_pos", 32'(lastpos[k]), 32'(e.size()));
        chk("busy_end", 32'(busy[k]), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_m_valid"}, 32'(m_valid[k]), 32'd0);
            chk({tag, "_m_last"}, 32'(m_last[k]), 32'd0);
            chk({tag, "_m_data"}, 32'(m_data[k]), 32'd0);
            chk({tag, "_s_ready"}, 32'(s_ready[k]), 32'd0);
            chk({tag, "_crc_en"}, 32'(crc_en[k]), 32'd0);
            chk({tag, "_crc_clr"}, 32'(crc_clr[k]), 32'd0);
            chk({tag, "_busy"}, 32'(busy[k]), 32'd0);
            chk({tag, "_frame_cnt"}, 32'(frame_cnt[k]), 32'd0);
        end
    endtask

    logic [7:0] pl[$];
    logic [7:0] pb[$];
    logic [7:0] ea[$];
    logic [7:0] eb[$];
    logic [7:0] q9[$];

    initial begin
        sel = 1'b0;
        s_data = 8'h00;
        s_valid = 1'b0;
        s_last = 1'b0;
        rnd = 1'b0;
        for (int i = 0; i < 9; i++) q9.push_back(8'(8'h31 + i));

        #1 rst_n = 1'b0;
        #11;
        check_reset_vals("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rdy_early", 32'(s_ready[0]), 32'd0);
        @(posedge clk);
        #1 chk("rdy_after", 32'(s_ready[0]), 32'd1);

        // "123456789" without pad, full-rate sink
        run_frame(1'b0, q9);
        chk("fcs_const", {oq[0][12], oq[0][11], oq[0][10], oq[0][9]},
            32'hCBF43926);
        chk("frame_cnt_1", 32'(frame_cnt[0]), 32'd1);

        // two-byte payload
        pl.delete();
        pl.push_back(8'h12);
        pl.push_back(8'hCD);
        run_frame(1'b0, pl);

        // one byte padded to 60
        pl.delete();
        pl.push_back(8'hAA);
        clear_mon(1'b1);
        send(1'b1, pl, 1'b1);
        chk("busy_pad", 32'(busy[1]), 32'd1);
        wait_out(1'b1, 64);
        chk("pad_beats", 32'(oq[1].size()), 32'd64);
        chk("pad_crc_en", 32'(nen[1]), 32'd60);
        check_residue(1'b1);
        build(1'b1, pl, ea);
        check_bytes(1'b1, ea);

        // stalled sink
        rnd = 1'b1;
        run_frame(1'b0, q9);
        rnd = 1'b0;

        // partial frame discarded by reset
        clear_mon(1'b0);
        pl.delete();
        pl.push_back(8'h31);
        pl.push_back(8'h32);
        pl.push_back(8'h33);
        send(1'b0, pl, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        chk("midrst_nolast", 32'(nlast[0]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(1'b0, q9);
        chk("post_rst_fcs",
            {oq[0][12], oq[0][11], oq[0][10], oq[0][9]}, 32'hCBF43926);
        chk("post_rst_cnt", 32'(frame_cnt[0]), 32'd1);

        // back-to-back random frames on the padding instance
        rnd = 1'b1;
        pl.delete();
        pb.delete();
        for (int i = 0; i < $urandom_range(1, 80); i++)
            pl.push_back(8'($urandom));
        for (int i = 0; i < $urandom_range(1, 80); i++)
            pb.push_back(8'($urandom));
        build(1'b1, pl, ea);
        build(1'b1, pb, eb);
        clear_mon(1'b1);
        send(1'b1, pl, 1'b1);
        send(1'b1, pb, 1'b1);
        foreach (eb[i]) ea.push_back(eb[i]);
        wait_out(1'b1, ea.size());
        check_bytes(1'b1, ea);
        chk("b2b_clr", 32'(nclr[1]), 32'd2);
        chk("b2b_last", 32'(nlast[1]), 32'd2);
        chk("b2b_frames", 32'(frame_cnt[1]), 32'd2);

        // assorted random frames
        for (int f = 0; f < 6; f++) begin
            pl.delete();
            for (int i = 0; i < $urandom_range(1, 70); i++)
                pl.push_back(8'($urandom));
            run_frame(1'(f % 2), pl);
        end
        rnd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
